// File: rtl/xmit_fifo_of_verifla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xmit_fifo_of_verifla_pkg
// Description : Shared verifla constants: sender state encodings, default depth.
// Revision    : 1.0 - initial release
// ============================================================================
package xmit_fifo_of_verifla_pkg;

    localparam int c_DEPTH_LOG2 = 4;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/xmit_fifo_of_verifla_if.sv
`default_nettype none
// ============================================================================
// Module      : xmit_fifo_of_verifla_if
// Description : Producer-side write port plus UART transmitter handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface xmit_fifo_of_verifla_if
    import xmit_fifo_of_verifla_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_DEPTH_LOG2
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  clr_ovf;
    logic                  xmitH;
    logic [7:0]            xmit_dataH;
    logic                  xmit_doneH;
    logic                  busy;

    // FIFO side
    modport slave (
        input  wr_en, wr_data, clr_ovf, xmit_doneH,
        output full, empty, count, overflow, xmitH, xmit_dataH, busy
    );

    // Producer / transmitter environment side
    modport master (
        output wr_en, wr_data, clr_ovf, xmit_doneH,
        input  full, empty, count, overflow, xmitH, xmit_dataH, busy
    );
endinterface
`default_nettype wire

// File: rtl/xmit_fifo_of_verifla_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_of_verifla
// Description : Single-clock byte FIFO with a dedicated occupancy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_of_verifla
    import xmit_fifo_of_verifla_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_DEPTH_LOG2
) (
    input  wire logic                  sys_clk,
    input  wire logic                  sys_rst_l,
    input  wire logic                  push,
    input  wire logic [7:0]            pushData,
    input  wire logic                  pop,
    output logic      [7:0]            popData,
    output logic      [DEPTH_LOG2:0]   count,
    output logic                       full,
    output logic                       empty
);
    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]              r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wrPtr;
    logic [DEPTH_LOG2-1:0]   r_rdPtr;
    logic [DEPTH_LOG2:0]     r_count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + 1'b1;
            if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign popData = r_mem[r_rdPtr];
    assign count   = r_count;
    assign full    = (r_count == (DEPTH_LOG2+1)'(c_DEPTH));
    assign empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/xmit_fifo_of_verifla.sv
`default_nettype none
// ============================================================================
// Module      : xmit_fifo_of_verifla
// Description : Byte FIFO feeding a UART transmitter through a 4-state sender.
// Revision    : 1.0 - initial release
// ============================================================================
module xmit_fifo_of_verifla
    import xmit_fifo_of_verifla_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_DEPTH_LOG2
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst_l,
    xmit_fifo_of_verifla_if.slave fifoIf
);
    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic [7:0]            r_xmitData;
    logic                  r_overflow;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovfSet;
    logic                  w_full;
    logic                  w_empty;
    logic [7:0]            w_head;
    logic [DEPTH_LOG2:0]   w_count;
    logic                  w_xmit;
    logic                  w_busy;

    // A pop frees a slot on the same edge, so a write while full is still taken.
    assign w_pop    = (r_state == c_ST_IDLE) && !w_empty && fifoIf.xmit_doneH;
    assign w_push   = fifoIf.wr_en && (!w_full || w_pop);
    assign w_ovfSet = fifoIf.wr_en && w_full && !w_pop;

    fifo_sync_of_verifla #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .push      (w_push),
        .pushData  (fifoIf.wr_data),
        .pop       (w_pop),
        .popData   (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_pop)              w_nextState = c_ST_ISSUE;
            c_ST_ISSUE:                             w_nextState = c_ST_WAIT_BUSY;
            c_ST_WAIT_BUSY: if (!fifoIf.xmit_doneH) w_nextState = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (fifoIf.xmit_doneH)  w_nextState = c_ST_IDLE;
            default:                                w_nextState = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_xmit = (r_state == c_ST_ISSUE);
        w_busy = (r_state != c_ST_IDLE);
    end

    // Clear wins over a coincident overflow set.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_xmitData <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) r_xmitData <= w_head;
            if (fifoIf.clr_ovf)  r_overflow <= 1'b0;
            else if (w_ovfSet)   r_overflow <= 1'b1;
        end
    end

    assign fifoIf.full       = w_full;
    assign fifoIf.empty      = w_empty;
    assign fifoIf.count      = w_count;
    assign fifoIf.overflow   = r_overflow;
    assign fifoIf.xmitH      = w_xmit;
    assign fifoIf.xmit_dataH = r_xmitData;
    assign fifoIf.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_xmit_fifo_of_verifla.sv
`default_nettype none
// ============================================================================
// Module      : tb_xmit_fifo_of_verifla
// Description : Directed bench with a UART transmitter model and byte logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xmit_fifo_of_verifla;
    import xmit_fifo_of_verifla_pkg::*;

    localparam int DL = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_l = 1'b0;

    xmit_fifo_of_verifla_if #(.DEPTH_LOG2(DL)) bus ();

    xmit_fifo_of_verifla #(.DEPTH_LOG2(DL)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_l (sys_rst_l),
        .fifoIf    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         nChecks   = 0;
    int         nPass     = 0;
    int         cycle     = 0;
    int         txLen     = 10;
    logic       holdDone  = 1'b0;
    int         txCnt     = 0;
    int         issueViol = 0;
    logic [7:0] txLog[$];
    int         issueCyc[$];

    // Transmitter model: idle-high, drops for txLen cycles after each strobe.
    assign bus.xmit_doneH = (txCnt == 0) && !holdDone;

    always @(posedge sys_clk) cycle <= cycle + 1;

    always @(negedge sys_clk) begin
        if (bus.xmitH) begin
            if (!bus.xmit_doneH) issueViol = issueViol + 1;
            if (issueCyc.size() > 0 && (cycle - issueCyc[issueCyc.size()-1]) < 4)
                issueViol = issueViol + 1;
            txLog.push_back(bus.xmit_dataH);
            issueCyc.push_back(cycle);
            txCnt = txLen;
        end else if (txCnt > 0) begin
            txCnt = txCnt - 1;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drain(input int maxCyc);
        bit done = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge sys_clk);
            if (bus.empty && !bus.busy && bus.xmit_doneH) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            nChecks++;
            $display("FAIL drain_timeout: count=%0d busy=%b after %0d cycles", bus.count, bus.busy, maxCyc);
        end
        tick();
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_ovf = 1'b0;
        sys_rst_l = 1'b0;
        #22;
        nChecks++; if (bus.count !== 5'd0)   $display("FAIL reset_count: got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.empty !== 1'b1)   $display("FAIL reset_empty: got %b want 1", bus.empty); else nPass++;
        nChecks++; if (bus.full !== 1'b0)    $display("FAIL reset_full: got %b want 0", bus.full); else nPass++;
        nChecks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else nPass++;
        nChecks++; if (bus.xmitH !== 1'b0)   $display("FAIL reset_xmitH: got %b want 0", bus.xmitH); else nPass++;
        nChecks++; if (bus.xmit_dataH !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.xmit_dataH); else nPass++;
        nChecks++; if (bus.busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", bus.busy); else nPass++;
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        txLen = 10; base = txLog.size();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.count !== 5'd1) $display("FAIL single_count1: got %0d want 1", bus.count); else nPass++;
        nChecks++; if (bus.xmitH !== 1'b0) $display("FAIL single_early_xmit: got %b want 0", bus.xmitH); else nPass++;
        @(negedge sys_clk);
        nChecks++; if (bus.xmitH !== 1'b1) $display("FAIL single_xmitH: got %b want 1", bus.xmitH); else nPass++;
        nChecks++; if (bus.xmit_dataH !== 8'hA5) $display("FAIL single_data: got %h want a5", bus.xmit_dataH); else nPass++;
        nChecks++; if (bus.count !== 5'd0) $display("FAIL single_count0: got %0d want 0", bus.count); else nPass++;
        tick();
        wait_drain(100);
        nChecks++; if (bus.xmit_dataH !== 8'hA5) $display("FAIL single_hold: got %h want a5", bus.xmit_dataH); else nPass++;
        nChecks++; if (txLog.size() - base !== 1) $display("FAIL single_nbytes: got %0d want 1", txLog.size() - base); else nPass++;
    endtask

    task automatic test_overflow();
        int base, errs;
        holdDone = 1'b1; base = txLog.size();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.full !== 1'b1)  $display("FAIL ovf_full: got %b want 1", bus.full); else nPass++;
        nChecks++; if (bus.count !== 5'd16) $display("FAIL ovf_count16: got %0d want 16", bus.count); else nPass++;
        nChecks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.overflow); else nPass++;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        tick();
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.overflow); else nPass++;
        nChecks++; if (bus.count !== 5'd16) $display("FAIL ovf_count_hold: got %0d want 16", bus.count); else nPass++;
        tick();
        bus.clr_ovf = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        tick();
        bus.clr_ovf = 1'b0; bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr_priority: got %b want 0", bus.overflow); else nPass++;
        tick();
        holdDone = 1'b0;
        wait_drain(600);
        nChecks++; if (txLog.size() - base !== 16) $display("FAIL ovf_nbytes: got %0d want 16", txLog.size() - base); else nPass++;
        errs = 0;
        for (int i = 0; i < 16 && base + i < txLog.size(); i++)
            if (txLog[base+i] !== 8'(i)) errs++;
        nChecks++; if (errs !== 0) $display("FAIL ovf_stream: got %0d wrong bytes want 0", errs); else nPass++;
    endtask

    task automatic test_full_pop();
        int base, errs;
        holdDone = 1'b1; base = txLog.size();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h20 + i);
            tick();
        end
        bus.wr_data = 8'h30; holdDone = 1'b0;
        tick();
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.count !== 5'd16) $display("FAIL fullpop_count: got %0d want 16", bus.count); else nPass++;
        nChecks++; if (bus.overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", bus.overflow); else nPass++;
        nChecks++; if (bus.xmit_dataH !== 8'h20) $display("FAIL fullpop_head: got %h want 20", bus.xmit_dataH); else nPass++;
        tick();
        wait_drain(600);
        nChecks++; if (txLog.size() - base !== 17) $display("FAIL fullpop_nbytes: got %0d want 17", txLog.size() - base); else nPass++;
        errs = 0;
        for (int i = 0; i < 17 && base + i < txLog.size(); i++)
            if (txLog[base+i] !== 8'(8'h20 + i)) errs++;
        nChecks++; if (errs !== 0) $display("FAIL fullpop_stream: got %0d wrong bytes want 0", errs); else nPass++;
    endtask

    task automatic test_back_to_back();
        int base, ib, v0;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        txLen = 10; holdDone = 1'b0;
        base = txLog.size(); ib = issueCyc.size(); v0 = issueViol;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = exp[i];
            tick();
        end
        bus.wr_en = 1'b0;
        wait_drain(200);
        nChecks++; if (txLog.size() - base !== 3) $display("FAIL b2b_nbytes: got %0d want 3", txLog.size() - base); else nPass++;
        if (txLog.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                nChecks++; if (txLog[base+i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, txLog[base+i], exp[i]); else nPass++;
            end
            nChecks++; if (issueCyc[ib+1] - issueCyc[ib] !== 12) $display("FAIL b2b_gap1: got %0d want 12", issueCyc[ib+1] - issueCyc[ib]); else nPass++;
            nChecks++; if (issueCyc[ib+2] - issueCyc[ib+1] !== 12) $display("FAIL b2b_gap2: got %0d want 12", issueCyc[ib+2] - issueCyc[ib+1]); else nPass++;
        end
        nChecks++; if (issueViol !== v0) $display("FAIL b2b_issue_rule: got %0d violations want 0", issueViol - v0); else nPass++;
    endtask

    task automatic test_reset_midbyte();
        int base;
        txLen = 10; holdDone = 1'b0; base = txLog.size();
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        nChecks++; if (bus.count !== 5'd5) $display("FAIL rstmid_queued: got %0d want 5", bus.count); else nPass++;
        nChecks++; if (bus.busy !== 1'b1)  $display("FAIL rstmid_busy: got %b want 1", bus.busy); else nPass++;
        #2 sys_rst_l = 1'b0;
        #1;
        nChecks++; if (bus.count !== 5'd0) $display("FAIL rstmid_count: got %0d want 0", bus.count); else nPass++;
        nChecks++; if (bus.empty !== 1'b1) $display("FAIL rstmid_empty: got %b want 1", bus.empty); else nPass++;
        nChecks++; if (bus.busy !== 1'b0)  $display("FAIL rstmid_idle: got %b want 0", bus.busy); else nPass++;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_l = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge sys_clk);
        nChecks++; if (txLog.size() - base !== 1) $display("FAIL rstmid_no_xmit: got %0d bytes want 1", txLog.size() - base); else nPass++;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        bus.wr_en = 1'b0;
        wait_drain(100);
        nChecks++; if (txLog.size() - base !== 2) $display("FAIL rstmid_resume_n: got %0d want 2", txLog.size() - base); else nPass++;
        nChecks++; if (txLog[txLog.size()-1] !== 8'h77) $display("FAIL rstmid_resume_data: got %h want 77", txLog[txLog.size()-1]); else nPass++;
    endtask

    task automatic test_wrap();
        int base, errs, idx, maxC, nb;
        txLen = 3; holdDone = 1'b0;
        base = txLog.size(); idx = 0; maxC = 0;
        for (int b = 0; b < 4; b++) begin
            nb = (b == 3) ? 4 : 12;
            for (int c = 0; c < nb + 50; c++) begin
                bus.wr_en   = (c < nb);
                bus.wr_data = 8'(8'h80 + idx);
                if (c < nb) idx++;
                @(negedge sys_clk);
                if (int'(bus.count) > maxC) maxC = int'(bus.count);
                tick();
            end
        end
        bus.wr_en = 1'b0;
        wait_drain(400);
        nChecks++; if (txLog.size() - base !== 40) $display("FAIL wrap_nbytes: got %0d want 40", txLog.size() - base); else nPass++;
        errs = 0;
        for (int i = 0; i < 40 && base + i < txLog.size(); i++)
            if (txLog[base+i] !== 8'(8'h80 + i)) errs++;
        nChecks++; if (errs !== 0) $display("FAIL wrap_stream: got %0d wrong bytes want 0", errs); else nPass++;
        nChecks++; if (maxC > 16) $display("FAIL wrap_maxcount: got %0d want <=16", maxC); else nPass++;
        nChecks++; if (bus.overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", bus.overflow); else nPass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_midbyte();
        test_wrap();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", nPass, nChecks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/xmit_fifo_of_verifla.md
XMIT_FIFO_OF_VERIFLA -- requirements
Module: xmit_fifo_of_verifla

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst_l  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port wr_en  in  1  one-cycle byte write strobe from the producer.
REQ-005 SHALL have port wr_data  in  8  byte written when wr_en=1.
REQ-006 SHALL have port full  out  1  high when count equals depth.
REQ-007 SHALL have port empty  out  1  high when count equals 0.
REQ-008 SHALL have port count  out  DEPTH_LOG2+1  number of stored bytes.
REQ-009 SHALL have port overflow  out  1  sticky flag, set by a write while full.
REQ-010 SHALL have port clr_ovf  in  1  clears overflow.
REQ-011 SHALL have port xmitH  out  1  one-cycle send strobe to the UART transmitter.
REQ-012 SHALL have port xmit_dataH  out  8  byte presented to the transmitter; stable from the xmitH cycle until the byte completes.
REQ-013 SHALL have port xmit_doneH  in  1  transmitter idle level; low while a byte is shifting.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL use a sender FSM with states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE->ISSUE SHALL occur when empty=0 and xmit_doneH=1; the head byte is popped into xmit_dataH on that edge.
REQ-017 In ISSUE, xmitH SHALL be 1 for exactly that cycle; the next state SHALL be WAIT_BUSY.
REQ-018 WAIT_BUSY->WAIT_DONE SHALL occur on the first cycle xmit_doneH=0.
REQ-019 WAIT_DONE->IDLE SHALL occur on the first cycle xmit_doneH=1.
REQ-020 Minimum spacing between consecutive xmitH pulses SHALL be 4 cycles; no byte SHALL be issued while xmit_doneH=0.
REQ-021 A write with full=0 SHALL store wr_data at the tail; count, full and empty SHALL update on the next edge.
REQ-022 A write with full=1 SHALL be dropped and SHALL set overflow; FIFO contents are unchanged.
REQ-023 Simultaneous write and pop SHALL leave count unchanged; a write while full that coincides with a pop SHALL be accepted, with no overflow.
REQ-024 A write into an empty FIFO SHALL be poppable no earlier than the following cycle, so write-to-xmitH latency is 2 cycles minimum.
REQ-025 Read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo depth.
REQ-026 count SHALL be held in its own register, not derived from pointer difference.
REQ-027 clr_ovf SHALL take priority over a simultaneous overflow set (overflow reads 0 next cycle).
REQ-028 Bytes SHALL be transmitted in write order, with no loss and no duplication.

Reset
REQ-029 On sys_rst_l=0: state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, xmitH=0, xmit_dataH=8'h00, busy=0.
REQ-030 Reset asserted mid-byte SHALL discard all queued bytes and the in-flight byte; after release, the FSM SHALL wait for xmit_doneH=1 before issuing anything.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 State encodings and the default DEPTH_LOG2 SHALL live in the shared verifla constants include file.
REQ-033 The storage SHALL be a sub-module fifo_sync_of_verifla, with push/pop/count/full/empty ports; the sender FSM SHALL be in the top level.
REQ-034 The block SHALL connect directly to the UART's xmitH/xmit_dataH/xmit_doneH ports with no glue logic.

Verification
REQ-035 Write 8'hA5 into an empty FIFO with xmit_doneH=1 -> xmitH pulses 2 cycles later, with xmit_dataH=8'hA5.
REQ-036 Write 16 bytes 0x00..0x0F, then a 17th byte 0xFF -> full=1 and overflow=1; the transmitted stream is 0x00..0x0F only.
REQ-037 Transmitter model holds xmit_doneH low for 10 cycles per byte; write 3 bytes back-to-back -> 3 xmitH pulses, each only after xmit_doneH returns high, in order.
REQ-038 With full=1, wr_en coincides with a pop -> count stays 16 and overflow stays 0.
REQ-039 Assert sys_rst_l low during WAIT_DONE with 5 bytes queued -> count=0 and empty=1 immediately; no xmitH after release until new data is written.
REQ-040 Write 40 bytes in bursts that cause pointer wrap twice -> all 40 bytes are sent in order, and the count never exceeds 16.
